bombe_flag_entry: RTL and testbench

//  Upstream feeder for the Bombe core: turns raw switch/button input into the <S0,S1,S2> flag sequence.

---
 rtl/bombe_flag_entry.sv | 146 ++++++++++++++
 tb/tb_bombe_flag_entry.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/bombe_flag_entry.sv
// Key/switch front end for the Bombe core: debounces the button, validates and
// upper-cases the switch character, and issues one load strobe per accepted press.
module bombe_flag_entry #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SETUP_CYCLES    = 2,
  parameter int PRESS_CYCLES    = 4,
  parameter int NUM_CHARS       = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sw_char,
  input  logic       key_raw,
  input  logic       clear,
  output logic [7:0] char_out,
  output logic       key_press,
  output logic [1:0] char_count,
  output logic       all_loaded,
  output logic       invalid_char
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMR_MAX = (SETUP_CYCLES > PRESS_CYCLES) ? SETUP_CYCLES : PRESS_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(SETUP_CYCLES - 1);
  localparam logic [TMR_W-1:0] PRESS_LAST = TMR_W'(PRESS_CYCLES - 1);
  localparam logic [1:0]       COUNT_FULL = 2'(NUM_CHARS);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    PRESS,
    WAIT_REL
  } state_t;

  state_t            state;
  logic [DB_W-1:0]   db_cnt;
  logic              key_db;
  logic              key_db_d;
  logic [TMR_W-1:0]  timer;
  logic              restart;
  logic              press;
  logic              is_upper;
  logic              is_lower;
  logic              char_valid;
  logic [7:0]        char_conv;

  assign restart = reset | clear;
  assign press   = key_db & ~key_db_d;

  always_comb begin
    is_upper   = (sw_char >= 8'h41) && (sw_char <= 8'h5A);
    is_lower   = (sw_char >= 8'h61) && (sw_char <= 8'h7A);
    char_valid = is_upper | is_lower;
    char_conv  = is_lower ? (sw_char - 8'h20) : sw_char;
  end

  // key_db only moves after key_raw has disagreed with it for the full window
  always_ff @(posedge clk) begin
    if (restart) begin
      db_cnt   <= '0;
      key_db   <= 1'b0;
      key_db_d <= 1'b0;
    end else begin
      key_db_d <= key_db;
      if (key_raw != key_db) begin
        if (db_cnt == DB_LAST) begin
          key_db <= key_raw;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      state        <= IDLE;
      timer        <= '0;
      char_out     <= 8'h41;
      key_press    <= 1'b0;
      char_count   <= 2'd0;
      all_loaded   <= 1'b0;
      invalid_char <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          key_press <= 1'b0;
          if (press) begin
            if (all_loaded) begin
              state <= WAIT_REL;
            end else if (char_valid) begin
              char_out     <= char_conv;
              invalid_char <= 1'b0;
              timer        <= '0;
              state        <= SETUP;
            end else begin
              invalid_char <= 1'b1;
              state        <= WAIT_REL;
            end
          end
        end

        SETUP: begin
          if (timer == SETUP_LAST) begin
            timer      <= '0;
            key_press  <= 1'b1;
            char_count <= char_count + 2'd1;
            all_loaded <= ((char_count + 2'd1) == COUNT_FULL);
            state      <= PRESS;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        PRESS: begin
          if (timer == PRESS_LAST) begin
            timer     <= '0;
            key_press <= 1'b0;
            state     <= WAIT_REL;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        WAIT_REL: begin
          // a held button must be released before another press can count
          key_press <= 1'b0;
          if (!key_db) begin
            state <= IDLE;
          end
        end

        default: begin
          key_press <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bombe_flag_entry.sv
// Directed bench for bombe_flag_entry with a short debounce window.
module tb_bombe_flag_entry;

  logic       clk;
  logic       reset;
  logic [7:0] sw_char;
  logic       key_raw;
  logic       clear;
  logic [7:0] char_out;
  logic       key_press;
  logic [1:0] char_count;
  logic       all_loaded;
  logic       invalid_char;

  int errors;
  int checks;

  int         mon_rises;
  int         mon_rise_tick;
  int         mon_high_ticks;
  logic [7:0] mon_char_rise;
  logic [7:0] mon_char_pre2;
  logic [7:0] mon_char_pre3;
  logic       mon_char_moved;

  bombe_flag_entry #(
    .DEBOUNCE_CYCLES(4),
    .SETUP_CYCLES(2),
    .PRESS_CYCLES(4),
    .NUM_CHARS(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw_char(sw_char),
    .key_raw(key_raw),
    .clear(clear),
    .char_out(char_out),
    .key_press(key_press),
    .char_count(char_count),
    .all_loaded(all_loaded),
    .invalid_char(invalid_char)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the key for 'hold' cycles, releases it, and records strobe activity.
  task automatic run_press(input logic [7:0] ch, input int hold, input bit toggle);
    logic [7:0] h1, h2, h3;
    logic       prev_kp;
    mon_rises = 0; mon_rise_tick = -1; mon_high_ticks = 0;
    mon_char_rise = 8'h00; mon_char_pre2 = 8'h00; mon_char_pre3 = 8'h00;
    mon_char_moved = 1'b0;
    prev_kp = key_press;
    h1 = char_out; h2 = char_out; h3 = char_out;
    sw_char = ch;
    key_raw = 1'b1;
    for (int i = 1; i <= hold + 12; i++) begin
      tick();
      if (key_press && !prev_kp) begin
        mon_rises++;
        if (mon_rise_tick < 0) begin
          mon_rise_tick = i;
          mon_char_rise = char_out;
          mon_char_pre2 = h2;
          mon_char_pre3 = h3;
        end
      end
      if (key_press) mon_high_ticks++;
      if (key_press && prev_kp && (char_out !== h1)) mon_char_moved = 1'b1;
      h3 = h2; h2 = h1; h1 = char_out; prev_kp = key_press;
      if (toggle && i >= 5) sw_char = 8'h41 + 8'(i % 26);
      if (i == hold) key_raw = 1'b0;
    end
  endtask

  task automatic pulse_clear();
    key_raw = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; key_raw = 1'b0; sw_char = 8'h00;
    tick(); tick();
    checks++; if (char_out !== 8'h41) begin errors++; $display("[TB] FAIL reset_char_out: got %h expected 41", char_out); end
    checks++; if (key_press !== 1'b0) begin errors++; $display("[TB] FAIL reset_key_press: got %b expected 0", key_press); end
    checks++; if (char_count !== 2'd0) begin errors++; $display("[TB] FAIL reset_char_count: got %0d expected 0", char_count); end
    checks++; if (all_loaded !== 1'b0) begin errors++; $display("[TB] FAIL reset_all_loaded: got %b expected 0", all_loaded); end
    checks++; if (invalid_char !== 1'b0) begin errors++; $display("[TB] FAIL reset_invalid: got %b expected 0", invalid_char); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_press();
    run_press(8'h51, 10, 1'b0);
    checks++; if (mon_rises !== 1) begin errors++; $display("[TB] FAIL single_rises: got %0d expected 1", mon_rises); end
    checks++; if (mon_rise_tick !== 7) begin errors++; $display("[TB] FAIL single_latency: got %0d expected 7", mon_rise_tick); end
    checks++; if (mon_high_ticks !== 4) begin errors++; $display("[TB] FAIL single_width: got %0d expected 4", mon_high_ticks); end
    checks++; if (mon_char_rise !== 8'h51) begin errors++; $display("[TB] FAIL single_char: got %h expected 51", mon_char_rise); end
    checks++; if (mon_char_pre2 !== 8'h51) begin errors++; $display("[TB] FAIL single_setup2: got %h expected 51", mon_char_pre2); end
    checks++; if (mon_char_pre3 !== 8'h41) begin errors++; $display("[TB] FAIL single_setup3: got %h expected 41", mon_char_pre3); end
    checks++; if (mon_char_moved !== 1'b0) begin errors++; $display("[TB] FAIL single_stable: got %b expected 0", mon_char_moved); end
    checks++; if (char_count !== 2'd1) begin errors++; $display("[TB] FAIL single_count: got %0d expected 1", char_count); end
  endtask

  task automatic test_bounce();
    int strobes;
    strobes = 0;
    sw_char = 8'h42;
    for (int b = 0; b < 5; b++) begin
      key_raw = 1'b1;
      for (int k = 0; k < 3; k++) begin tick(); if (key_press) strobes++; end
      key_raw = 1'b0;
      for (int k = 0; k < 2; k++) begin tick(); if (key_press) strobes++; end
    end
    checks++; if (strobes !== 0) begin errors++; $display("[TB] FAIL bounce_no_strobe: got %0d expected 0", strobes); end
    checks++; if (invalid_char !== 1'b0) begin errors++; $display("[TB] FAIL bounce_invalid: got %b expected 0", invalid_char); end
    run_press(8'h42, 10, 1'b0);
    checks++; if (mon_rises !== 1) begin errors++; $display("[TB] FAIL bounce_rises: got %0d expected 1", mon_rises); end
    checks++; if (mon_rise_tick !== 7) begin errors++; $display("[TB] FAIL bounce_latency: got %0d expected 7", mon_rise_tick); end
    checks++; if (char_count !== 2'd2) begin errors++; $display("[TB] FAIL bounce_count: got %0d expected 2", char_count); end
  endtask

  task automatic test_convert_invalid();
    pulse_clear();
    checks++; if (char_count !== 2'd0) begin errors++; $display("[TB] FAIL clear_count: got %0d expected 0", char_count); end
    run_press(8'h7A, 10, 1'b0);
    checks++; if (mon_char_rise !== 8'h5A) begin errors++; $display("[TB] FAIL lower_conv: got %h expected 5A", mon_char_rise); end
    run_press(8'h35, 10, 1'b0);
    checks++; if (mon_rises !== 0) begin errors++; $display("[TB] FAIL invalid_rises: got %0d expected 0", mon_rises); end
    checks++; if (invalid_char !== 1'b1) begin errors++; $display("[TB] FAIL invalid_flag: got %b expected 1", invalid_char); end
    checks++; if (char_out !== 8'h5A) begin errors++; $display("[TB] FAIL invalid_char_hold: got %h expected 5A", char_out); end
    checks++; if (char_count !== 2'd1) begin errors++; $display("[TB] FAIL invalid_count: got %0d expected 1", char_count); end
  endtask

  task automatic test_saturate();
    pulse_clear();
    run_press(8'h58, 10, 1'b0);
    run_press(8'h59, 10, 1'b0);
    checks++; if (all_loaded !== 1'b0) begin errors++; $display("[TB] FAIL sat_early_loaded: got %b expected 0", all_loaded); end
    run_press(8'h5A, 10, 1'b0);
    checks++; if (all_loaded !== 1'b1) begin errors++; $display("[TB] FAIL sat_loaded: got %b expected 1", all_loaded); end
    checks++; if (char_count !== 2'd3) begin errors++; $display("[TB] FAIL sat_count: got %0d expected 3", char_count); end
    run_press(8'h41, 10, 1'b0);
    checks++; if (mon_rises !== 0) begin errors++; $display("[TB] FAIL sat_extra_rises: got %0d expected 0", mon_rises); end
    checks++; if (char_out !== 8'h5A) begin errors++; $display("[TB] FAIL sat_char_hold: got %h expected 5A", char_out); end
    checks++; if (char_count !== 2'd3) begin errors++; $display("[TB] FAIL sat_count_hold: got %0d expected 3", char_count); end
  endtask

  task automatic test_reset_mid_press();
    int waited;
    int strobes;
    pulse_clear();
    sw_char = 8'h4B;
    key_raw = 1'b1;
    waited = 0;
    while (!key_press && waited < 20) begin tick(); waited++; end
    checks++; if (key_press !== 1'b1) begin errors++; $display("[TB] FAIL midreset_strobe_seen: got %b expected 1 within 20 cycles", key_press); end
    tick();
    checks++; if (char_count !== 2'd1) begin errors++; $display("[TB] FAIL midreset_count_before: got %0d expected 1", char_count); end
    reset = 1'b1;
    key_raw = 1'b0;
    tick();
    reset = 1'b0;
    checks++; if (key_press !== 1'b0) begin errors++; $display("[TB] FAIL midreset_key_press: got %b expected 0", key_press); end
    checks++; if (char_count !== 2'd0) begin errors++; $display("[TB] FAIL midreset_count: got %0d expected 0", char_count); end
    checks++; if (char_out !== 8'h41) begin errors++; $display("[TB] FAIL midreset_char: got %h expected 41", char_out); end
    checks++; if (all_loaded !== 1'b0) begin errors++; $display("[TB] FAIL midreset_loaded: got %b expected 0", all_loaded); end
    strobes = 0;
    for (int k = 0; k < 10; k++) begin tick(); if (key_press) strobes++; end
    checks++; if (strobes !== 0) begin errors++; $display("[TB] FAIL midreset_no_extend: got %0d expected 0", strobes); end
  endtask

  task automatic test_long_hold();
    pulse_clear();
    run_press(8'h4D, 1000, 1'b1);
    checks++; if (mon_rises !== 1) begin errors++; $display("[TB] FAIL hold_rises: got %0d expected 1", mon_rises); end
    checks++; if (mon_high_ticks !== 4) begin errors++; $display("[TB] FAIL hold_width: got %0d expected 4", mon_high_ticks); end
    checks++; if (mon_char_rise !== 8'h4D) begin errors++; $display("[TB] FAIL hold_char_rise: got %h expected 4D", mon_char_rise); end
    checks++; if (char_out !== 8'h4D) begin errors++; $display("[TB] FAIL hold_char_end: got %h expected 4D", char_out); end
    checks++; if (char_count !== 2'd1) begin errors++; $display("[TB] FAIL hold_count: got %0d expected 1", char_count); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    clear = 1'b0;
    key_raw = 1'b0;
    sw_char = 8'h00;
    test_reset();
    test_single_press();
    test_bounce();
    test_convert_invalid();
    test_saturate();
    test_reset_mid_press();
    test_long_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
